mme_operand_skewer: RTL and testbench

Upstream feeder for the MME systolic PE array. Accepts one A column vector and one B row vector per beat over valid/ready. Drives them onto the array's west (A) and north (B) edges with diagonal skew. Sequences the array's clr/hold controls over a K-beat matrix multiply, then drains and signals completion.

---
 rtl/mme_operand_skewer_if.sv | 36 +++
 rtl/mme_operand_skewer.sv | 179 +++++++++++++++++
 tb/tb_mme_operand_skewer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mme_operand_skewer_if.sv
// Operand handshake bundle between the A/B operand sources and the MME skewer.
// Latency: none; this is wiring only.
// Backpressure: each ready is returned by the skewer and only completes a transfer jointly with the other side's valid.
interface mme_operand_skewer_if #(
  parameter int SIZE = 4,
  parameter int DW   = 32
);

  logic               a_valid_i;
  logic               a_ready_o;
  logic [SIZE*DW-1:0] a_data_i;
  logic               b_valid_i;
  logic               b_ready_o;
  logic [SIZE*DW-1:0] b_data_i;

  // Operand source side: offers A column and B row beats
  modport master (
    output a_valid_i,
    output a_data_i,
    output b_valid_i,
    output b_data_i,
    input  a_ready_o,
    input  b_ready_o
  );

  // Skewer side: consumes A/B beats in pairs
  modport slave (
    input  a_valid_i,
    input  a_data_i,
    input  b_valid_i,
    input  b_data_i,
    output a_ready_o,
    output b_ready_o
  );

endinterface

// File: rtl/mme_operand_skewer.sv
// Feeds the systolic PE array: diagonally skews A (west) / B (north) beats and sequences clr/hold for a K-beat job.
// Latency: beat fired in cycle t reaches edge lane i in cycle t+1+i; done_o at start+2+K+2*SIZE-1 with no stalls.
// Backpressure: A and B transfer only together; a missing side stalls the skew pipes and freezes the array (hold_o).
module mme_operand_skewer #(
  parameter int SIZE = 4,
  parameter int DW   = 32,
  parameter int KW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [KW-1:0]        k_len_i,
  mme_operand_skewer_if.slave  op,
  output logic [SIZE*DW-1:0]   a_o,
  output logic [SIZE*DW-1:0]   b_o,
  output logic                 clr_o,
  output logic                 hold_o,
  output logic                 busy_o,
  output logic                 done_o
);

  // The drain must flush the diagonal wavefront through the whole array:
  // SIZE cycles of edge skew plus SIZE-1 hops across to PE[SIZE-1][SIZE-1].
  localparam int DRAIN_LEN = 2 * SIZE - 1;
  localparam int DCW       = $clog2(DRAIN_LEN + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;

  logic            fire;
  logic            shift;

  // A beat is taken only when both operands are present in FEED
  assign fire  = (state_q == ST_FEED) && op.a_valid_i && op.b_valid_i;
  // Skew pipes advance on a fired beat or on every drain cycle (zeros in)
  assign shift = fire || (state_q == ST_DRAIN);

  // Each side is ready exactly when the other side is valid, so neither
  // operand can be consumed without its partner.
  assign op.a_ready_o = (state_q == ST_FEED) && op.b_valid_i;
  assign op.b_ready_o = (state_q == ST_FEED) && op.a_valid_i;

  // Job sequencing: next state, latched K, beat and drain counters
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          k_d     = k_len_i;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        beat_cnt_d  = '0;
        drain_cnt_d = '0;
        state_d     = (k_q != '0) ? ST_FEED : ST_DONE;
      end
      ST_FEED: begin
        if (fire) begin
          beat_cnt_d = beat_cnt_q + KW'(1);
          // K >= 1 here and the count stops at K, so the +1 never wraps
          if (beat_cnt_q + KW'(1) == k_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Array controls decoded from the state register; FEED hold follows fire
  always_comb begin
    clr_o  = (state_q == ST_CLEAR);
    busy_o = (state_q != ST_IDLE);
    done_o = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE:  hold_o = 1'b1;
      ST_CLEAR: hold_o = 1'b0;
      ST_FEED:  hold_o = !fire;
      ST_DRAIN: hold_o = 1'b0;
      ST_DONE:  hold_o = 1'b1;
      default:  hold_o = 1'b1;
    endcase
  end

  // Lane i carries i+1 stages so successive lanes lag by one cycle,
  // forming the diagonal wavefront the systolic array expects.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
    logic [DW-1:0] a_sr_q [gi+1];
    logic [DW-1:0] a_sr_d [gi+1];
    logic [DW-1:0] b_sr_q [gi+1];
    logic [DW-1:0] b_sr_d [gi+1];
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;

    // Only a fired beat enters; drain cycles push zeros behind it
    assign a_in = fire ? op.a_data_i[gi*DW +: DW] : '0;
    assign b_in = fire ? op.b_data_i[gi*DW +: DW] : '0;

    // Shift on advancing cycles, wipe in CLEAR, otherwise hold with the array
    always_comb begin
      a_sr_d = a_sr_q;
      b_sr_d = b_sr_q;
      if (state_q == ST_CLEAR) begin
        for (int j = 0; j <= gi; j++) begin
          a_sr_d[j] = '0;
          b_sr_d[j] = '0;
        end
      end else if (shift) begin
        a_sr_d[0] = a_in;
        b_sr_d[0] = b_in;
        for (int j = 1; j <= gi; j++) begin
          a_sr_d[j] = a_sr_q[j-1];
          b_sr_d[j] = b_sr_q[j-1];
        end
      end
    end

    // Skew stage registers with synchronous reset
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int j = 0; j <= gi; j++) begin
          a_sr_q[j] <= '0;
          b_sr_q[j] <= '0;
        end
      end else begin
        for (int j = 0; j <= gi; j++) begin
          a_sr_q[j] <= a_sr_d[j];
          b_sr_q[j] <= b_sr_d[j];
        end
      end
    end

    assign a_o[gi*DW +: DW] = a_sr_q[gi];
    assign b_o[gi*DW +: DW] = b_sr_q[gi];
  end

endmodule

// File: tb/tb_mme_operand_skewer.sv
// Self-checking bench for mme_operand_skewer with a lane scoreboard and a 4x4 PE array model.
// Latency: checks exact clr/done/busy cycles and per-lane skew arrival.
// Backpressure: exercises B-side stalls, start-ignored cases and mid-job reset.
module tb_mme_operand_skewer;

  localparam int SIZE = 4;
  localparam int DW   = 32;
  localparam int KW   = 16;
  localparam int VW   = SIZE * DW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic [KW-1:0]  k_len_i = '0;
  logic [VW-1:0]  a_o, b_o;
  logic           clr_o, hold_o, busy_o, done_o;

  mme_operand_skewer_if #(.SIZE(SIZE), .DW(DW)) sif ();

  mme_operand_skewer #(.SIZE(SIZE), .DW(DW), .KW(KW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .k_len_i (k_len_i),
    .op      (sif),
    .a_o     (a_o),
    .b_o     (b_o),
    .clr_o   (clr_o),
    .hold_o  (hold_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec4(input int x0, input int x1, input int x2, input int x3);
    return {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- lane scoreboard ----------------
  logic [DW-1:0] sb_a [SIZE][$];
  logic [DW-1:0] sb_b [SIZE][$];
  logic [DW-1:0] prev_a [SIZE];
  logic [DW-1:0] prev_b [SIZE];
  int done_cnt = 0;

  task automatic sb_push(input logic [VW-1:0] a, input logic [VW-1:0] b);
    for (int i = 0; i < SIZE; i++) begin
      if (a[i*DW +: DW] != '0) sb_a[i].push_back(a[i*DW +: DW]);
      if (b[i*DW +: DW] != '0) sb_b[i].push_back(b[i*DW +: DW]);
    end
  endtask

  task automatic drive(input logic [VW-1:0] a, input logic [VW-1:0] b);
    sif.a_valid_i = 1'b1;
    sif.b_valid_i = 1'b1;
    sif.a_data_i  = a;
    sif.b_data_i  = b;
    sb_push(a, b);
  endtask

  task automatic idle_in();
    sif.a_valid_i = 1'b0;
    sif.b_valid_i = 1'b0;
    sif.a_data_i  = '0;
    sif.b_data_i  = '0;
  endtask

  // A new nonzero value on a lane is the next beat arriving there
  always @(negedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      logic [DW-1:0] la, lb;
      la = a_o[i*DW +: DW];
      lb = b_o[i*DW +: DW];
      if (la != prev_a[i] && la != '0) begin
        if (sb_a[i].size() == 0) check("sb_a_unexpected", VW'(la), '0);
        else check("sb_a_lane", VW'(la), VW'(sb_a[i].pop_front()));
      end
      if (lb != prev_b[i] && lb != '0) begin
        if (sb_b[i].size() == 0) check("sb_b_unexpected", VW'(lb), '0);
        else check("sb_b_lane", VW'(lb), VW'(sb_b[i].pop_front()));
      end
      prev_a[i] = la;
      prev_b[i] = lb;
      if (!rst_n) begin
        sb_a[i].delete();
        sb_b[i].delete();
      end
    end
    if (done_o) done_cnt++;
  end

  // ---------------- 4x4 PE array model ----------------
  logic [DW-1:0] pa  [SIZE][SIZE];
  logic [DW-1:0] pb  [SIZE][SIZE];
  logic [DW-1:0] acc [SIZE][SIZE];
  logic [VW-1:0] s_a, s_b;
  logic          s_clr, s_hold;

  always @(negedge clk) begin
    s_a    = a_o;
    s_b    = b_o;
    s_clr  = clr_o;
    s_hold = hold_o;
  end

  always @(posedge clk) begin
    logic [DW-1:0] na [SIZE][SIZE];
    logic [DW-1:0] nb [SIZE][SIZE];
    logic [DW-1:0] ain, bin;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (j == 0) ain = s_a[i*DW +: DW];
        else        ain = pa[i][j-1];
        if (i == 0) bin = s_b[j*DW +: DW];
        else        bin = pb[i-1][j];
        if (s_clr) begin
          acc[i][j] = '0;
          na[i][j]  = '0;
          nb[i][j]  = '0;
        end else if (!s_hold) begin
          acc[i][j] = acc[i][j] + ain * bin;
          na[i][j]  = ain;
          nb[i][j]  = bin;
        end else begin
          na[i][j]  = pa[i][j];
          nb[i][j]  = pb[i][j];
        end
      end
    end
    pa = na;
    pb = nb;
  end

  task automatic wait_done(input int exp_cyc, input string tag);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done_o) break;
    end
    check(tag, VW'(cyc), VW'(exp_cyc));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    int nd;
    logic [VW-1:0] a, b, ea, eb;
    logic [VW-1:0] ba [4];
    logic [VW-1:0] bb [4];

    for (int i = 0; i < SIZE; i++) begin
      prev_a[i] = '0;
      prev_b[i] = '0;
    end
    idle_in();

    // ---- reset values ----
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_a_o", a_o, '0);
    check("rst_b_o", b_o, '0);
    check("rst_clr", VW'(clr_o), '0);
    check("rst_hold", VW'(hold_o), VW'(1'b1));
    check("rst_busy", VW'(busy_o), '0);
    check("rst_done", VW'(done_o), '0);
    check("rst_a_ready", VW'(sif.a_ready_o), '0);
    check("rst_b_ready", VW'(sif.b_ready_o), '0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // ---- test 1: K=1, exact skew and done timing ----
    s = cyc;
    start_i = 1'b1; k_len_i = 16'd1;
    tick();
    start_i = 1'b0; k_len_i = '0;
    @(negedge clk);
    check("t1_clr", VW'(clr_o), VW'(1'b1));
    check("t1_hold_clear", VW'(hold_o), '0);
    check("t1_busy_clear", VW'(busy_o), VW'(1'b1));
    tick();
    a = vec4(1, 2, 3, 4);
    b = vec4(5, 6, 7, 8);
    drive(a, b);
    @(negedge clk);
    check("t1_a_ready", VW'(sif.a_ready_o), VW'(1'b1));
    check("t1_b_ready", VW'(sif.b_ready_o), VW'(1'b1));
    check("t1_hold_fire", VW'(hold_o), '0);
    tick();
    idle_in();
    for (int c = 3; c <= 11; c++) begin
      @(negedge clk);
      ea = '0;
      eb = '0;
      for (int i = 0; i < SIZE; i++) begin
        if (c == 3 + i) begin
          ea[i*DW +: DW] = a[i*DW +: DW];
          eb[i*DW +: DW] = b[i*DW +: DW];
        end
      end
      check("t1_a_o", a_o, ea);
      check("t1_b_o", b_o, eb);
      check("t1_done", VW'(done_o), VW'(c == 10));
      check("t1_busy", VW'(busy_o), VW'(c <= 10));
      tick();
    end

    // ---- test 2: K=3 with two B-side stall cycles ----
    for (int k = 0; k < 4; k++) begin
      ba[k] = vec4(16*k + 17, 16*k + 18, 16*k + 19, 16*k + 20);
      bb[k] = vec4(16*k + 257, 16*k + 258, 16*k + 259, 16*k + 260);
    end
    s = cyc;
    start_i = 1'b1; k_len_i = 16'd3;
    tick();
    start_i = 1'b0;
    tick();
    drive(ba[0], bb[0]);
    tick();
    sif.a_valid_i = 1'b1;
    sif.b_valid_i = 1'b0;
    sif.a_data_i  = ba[1];
    sif.b_data_i  = bb[1];
    ea = '0;
    eb = '0;
    ea[0 +: DW] = ba[0][0 +: DW];
    eb[0 +: DW] = bb[0][0 +: DW];
    for (int st = 0; st < 2; st++) begin
      @(negedge clk);
      check("t2_stall_a_ready", VW'(sif.a_ready_o), '0);
      check("t2_stall_b_ready", VW'(sif.b_ready_o), VW'(1'b1));
      check("t2_stall_hold", VW'(hold_o), VW'(1'b1));
      check("t2_stall_a_o", a_o, ea);
      check("t2_stall_b_o", b_o, eb);
      tick();
    end
    sif.b_valid_i = 1'b1;
    sb_push(ba[1], bb[1]);
    @(negedge clk);
    check("t2_resume_a_ready", VW'(sif.a_ready_o), VW'(1'b1));
    check("t2_resume_a_o", a_o, ea);
    tick();
    drive(ba[2], bb[2]);
    tick();
    idle_in();
    wait_done(s + 14, "t2_done_cycle");
    tick();

    // ---- test 3: identity A times B through a PE array model ----
    s = cyc;
    start_i = 1'b1; k_len_i = 16'd4;
    tick();
    start_i = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      a = '0;
      a[k*DW +: DW] = DW'(1);
      b = vec4(4*k + 1, 4*k + 2, 4*k + 3, 4*k + 4);
      drive(a, b);
      tick();
    end
    idle_in();
    wait_done(s + 13, "t3_done_cycle");
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        check("t3_accum", VW'(acc[i][j]), VW'(4*i + j + 1));
    repeat (5) tick();
    @(negedge clk);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        check("t3_accum_idle", VW'(acc[i][j]), VW'(4*i + j + 1));
    check("t3_idle_a_o", a_o, '0);
    tick();

    // ---- test 4: K=0, no handshake ----
    s = cyc;
    start_i = 1'b1; k_len_i = 16'd0;
    tick();
    start_i = 1'b0;
    sif.a_valid_i = 1'b1;
    sif.b_valid_i = 1'b1;
    sif.a_data_i  = vec4(9, 9, 9, 9);
    sif.b_data_i  = vec4(9, 9, 9, 9);
    @(negedge clk);
    check("t4_clr", VW'(clr_o), VW'(1'b1));
    check("t4_a_ready_clear", VW'(sif.a_ready_o), '0);
    check("t4_b_ready_clear", VW'(sif.b_ready_o), '0);
    tick();
    @(negedge clk);
    check("t4_done", VW'(done_o), VW'(1'b1));
    check("t4_hold_done", VW'(hold_o), VW'(1'b1));
    check("t4_a_ready_done", VW'(sif.a_ready_o), '0);
    check("t4_b_ready_done", VW'(sif.b_ready_o), '0);
    check("t4_a_o", a_o, '0);
    check("t4_b_o", b_o, '0);
    tick();
    idle_in();
    @(negedge clk);
    check("t4_busy_after", VW'(busy_o), '0);
    tick();

    // ---- test 5: start ignored in FEED and in DONE ----
    s = cyc;
    start_i = 1'b1; k_len_i = 16'd2;
    tick();
    start_i = 1'b0;
    tick();
    drive(ba[3], bb[3]);
    tick();
    idle_in();
    start_i = 1'b1; k_len_i = 16'd7;
    @(negedge clk);
    check("t5_busy_feed", VW'(busy_o), VW'(1'b1));
    check("t5_hold_stall", VW'(hold_o), VW'(1'b1));
    tick();
    start_i = 1'b0;
    drive(ba[0], bb[0]);
    tick();
    idle_in();
    while (cyc < s + 12) tick();
    start_i = 1'b1; k_len_i = 16'd5;
    @(negedge clk);
    check("t5_done", VW'(done_o), VW'(1'b1));
    tick();
    start_i = 1'b0; k_len_i = '0;
    @(negedge clk);
    check("t5_idle_busy", VW'(busy_o), '0);
    check("t5_idle_hold", VW'(hold_o), VW'(1'b1));
    check("t5_idle_clr", VW'(clr_o), '0);
    tick();
    @(negedge clk);
    check("t5_idle_busy2", VW'(busy_o), '0);
    tick();

    // ---- test 6: reset mid-FEED, then a fresh job ----
    s = cyc;
    start_i = 1'b1; k_len_i = 16'd4;
    tick();
    start_i = 1'b0;
    tick();
    drive(ba[1], bb[1]);
    tick();
    drive(ba[2], bb[2]);
    tick();
    idle_in();
    rst_n = 1'b0;
    nd = done_cnt;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_busy", VW'(busy_o), '0);
    check("t6_hold", VW'(hold_o), VW'(1'b1));
    check("t6_a_o", a_o, '0);
    check("t6_b_o", b_o, '0);
    check("t6_done", VW'(done_o), '0);
    repeat (12) tick();
    check("t6_no_done", VW'(done_cnt), VW'(nd));
    s = cyc;
    start_i = 1'b1; k_len_i = 16'd1;
    tick();
    start_i = 1'b0;
    tick();
    drive(ba[3], bb[3]);
    tick();
    idle_in();
    wait_done(s + 10, "t6_fresh_done_cycle");
    tick();

    // ---- every queued lane value must have arrived ----
    for (int i = 0; i < SIZE; i++) begin
      check("sb_a_left", VW'(sb_a[i].size()), '0);
      check("sb_b_left", VW'(sb_b[i].size()), '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
